// File: rtl/freq_meter.sv
// Measures the period and high time of a slow divided clock (sig_in) in clk cycles.
// Define FREQ_METER_DUTY_EN to build the high-time counter; otherwise high_time reads 0.
`timescale 1ns/1ps
module freq_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             s_meta, s_q, s_d;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic             cnt_max;
  logic             post_result, post_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add_bit(input logic [CNT_W-1:0] v,
                                                   input logic b);
    return (b && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  // Input conditioning: two-flop synchronizer then an edge-detect flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_q    <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      s_meta <= sig_in;
      s_q    <= s_meta;
      s_d    <= s_q;
    end
  end

  assign rise    = s_q & ~s_d;
  assign cnt_max = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     if (rise) state_nxt = MEAS;
               else if (cnt_max) state_nxt = IDLE;
      MEAS:    if (rise || cnt_max) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A closing rise takes priority over the saturation limit
  always_comb begin
    busy         = (state != IDLE);
    post_result  = (state == MEAS) && rise;
    post_timeout = (state != IDLE) && !rise && cnt_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      period  <= '0;
    end else begin
      done <= post_result | post_timeout;
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          timeout <= 1'b0;
        end
        ARM:  cnt <= rise ? CNT_W'(1) : sat_inc(cnt);
        MEAS: cnt <= sat_inc(cnt);
        default: cnt <= '0;
      endcase
      if (post_result) period <= cnt;
      if (post_timeout) begin
        period  <= '0;
        timeout <= 1'b1;
      end
    end
  end

`ifdef FREQ_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      if (state == ARM && rise)        hcnt <= CNT_W'(1);
      else if (state == MEAS && !rise) hcnt <= sat_add_bit(hcnt, s_q);
      if (post_result)  high_time <= hcnt;
      if (post_timeout) high_time <= '0;
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Randomized self-checking bench for freq_meter: a clock-divider generator drives sig_in
// and results are compared with the divide factor / high count chosen for the divider.
`timescale 1ns/1ps
module tb_freq_meter;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in = 1'b0;
  logic             start;
  logic             busy, done, timeout;
  logic [CNT_W-1:0] period, high_time;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  int div_n = 0, div_h = 0;
  bit div_lvl = 1'b0;
  int ph = 0, last_n = -1, last_h = -1;

  freq_meter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start),
    .busy(busy), .done(done), .period(period), .high_time(high_time),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Divide-by-N source: high for H of every N clk cycles, or a constant level when N=0
  always @(posedge clk) begin
    #2;
    if (div_n != last_n || div_h != last_h) begin
      ph = 0; last_n = div_n; last_h = div_h;
    end
    if (div_n == 0) sig_in = div_lvl;
    else begin
      sig_in = (ph < div_h);
      ph = (ph + 1 >= div_n) ? 0 : ph + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_high(input int h);
`ifdef FREQ_METER_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  task automatic wait_done(input int limit, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic set_div(input int n, input int h, input bit lvl);
    div_n = n; div_h = h; div_lvl = lvl;
    repeat (2 * n + 8) @(negedge clk);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_on"}, busy, 1);
    chk({tag, " tmo_clr"}, timeout, 0);
  endtask

  task automatic measure(input string tag, input int n, input int h);
    int cyc;
    bit ok;
    set_div(n, h, 1'b0);
    pulse_start(tag);
    wait_done(3 * n + 20, cyc, ok);
    chk({tag, " done"}, ok, 1);
    chk({tag, " period"}, period, n);
    chk({tag, " high"}, high_time, exp_high(h));
    chk({tag, " timeout"}, timeout, 0);
    @(negedge clk);
    chk({tag, " busy_off"}, busy, 0);
    chk({tag, " done_1cyc"}, done, 0);
  endtask

  task automatic timeout_test(input string tag, input int n, input bit lvl, input int lo,
                              input int hi);
    int cyc;
    bit ok;
    set_div(n, n / 2, lvl);
    pulse_start(tag);
    wait_done(hi + 20, cyc, ok);
    chk({tag, " done"}, ok, 1);
    chk({tag, " cycles_ok"}, (cyc >= lo && cyc <= hi), 1);
    chk({tag, " timeout"}, timeout, 1);
    chk({tag, " period"}, period, 0);
    chk({tag, " high"}, high_time, 0);
    @(negedge clk);
    chk({tag, " busy_off"}, busy, 0);
  endtask

  initial begin
    int cyc, base, n, h;
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst period", period, 0);
    chk("rst high", high_time, 0);
    chk("rst timeout", timeout, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    measure("n4", 4, 2);
    measure("n10", 10, 5);
    measure("n8", 8, 4);

    // Back-to-back measurements with start held high
    set_div(5, 2, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done(40, cyc, ok);
      if (i == 2) start = 1'b0;
      chk($sformatf("b2b%0d done", i), ok, 1);
      chk($sformatf("b2b%0d period", i), period, 5);
      chk($sformatf("b2b%0d high", i), high_time, exp_high(2));
    end
    @(negedge clk);
    chk("b2b busy_off", busy, 0);

    // Dead input, low then high, then a normal measurement clears timeout
    timeout_test("tmo_low", 0, 1'b0, 254, 258);
    timeout_test("tmo_high", 0, 1'b1, 254, 258);
    measure("after_tmo", 4, 2);

    // Period exactly at the limit is a valid result; one longer aborts in MEAS
    measure("n255", 255, 100);
    timeout_test("n256", 256, 1'b0, 255, 520);

    // start while busy is ignored
    set_div(4, 2, 1'b0);
    base = done_cnt;
    pulse_start("busy_start");
    repeat (2) @(negedge clk);
    chk("busy_start still_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, cyc, ok);
    chk("busy_start done", ok, 1);
    chk("busy_start period", period, 4);
    repeat (15) @(negedge clk);
    chk("busy_start one_done", done_cnt - base, 1);

    // Asynchronous reset mid-measurement
    pulse_start("mid_rst");
    repeat (3) @(negedge clk);
    base = done_cnt;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst busy", busy, 0);
    chk("mid_rst done", done, 0);
    chk("mid_rst period", period, 0);
    chk("mid_rst high", high_time, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst no_done", done_cnt - base, 0);
    measure("post_rst", 4, 2);

    // Random divider settings
    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(30, 2));
      h = int'($urandom_range(n - 1, 1));
      measure($sformatf("rnd%0d_n%0d_h%0d", i, n, h), n, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measurement counterpart to the team's clock divider: observes a divided clock (`sig_in`) and recovers its period in `clk` cycles, plus high time.
- Used in benches and on-chip self-test to confirm the divider's divide factor N and duty cycle.
- A single measurement is triggered by `start`; the result is flagged by a one-cycle `done` pulse.
- Guards against a dead input with a saturating timeout.

Parameters:
- CNT_W, 16, width of period/high-time counters and result outputs; timeout limit = 2^CNT_W-1 cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  divided clock under measurement; treated as asynchronous.
- start  input  1  pulse or level; sampled in IDLE only.
- busy  output  1  high while a measurement is in progress.
- done  output  1  one-cycle pulse when a result or timeout is posted.
- period  output  CNT_W  clk cycles between consecutive sig_in rising edges.
- high_time  output  CNT_W  clk cycles sig_in was high within that period.
- timeout  output  1  sticky; set when a measurement aborts.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy, done, timeout, period, high_time, all counters = 0.
  - Synchronizer flops = 0.
- Input conditioning:
  - sig_in goes through a 2-flop synchronizer giving s_q, then one more flop giving s_d.
  - rise = s_q & ~s_d.
  - Input-to-rise latency is 2 clk; this does not bias the measured period.
- States:
  - IDLE: start=1 -> ARM; clear timeout and cnt; busy=1 from the next cycle.
  - ARM:
    - Waits for the first rise.
    - On rise: cnt<=1, hcnt<=1, go to MEAS.
    - Otherwise cnt increments.
  - MEAS:
    - Non-rise cycle: cnt<=cnt+1, hcnt<=hcnt+s_q.
    - Rise cycle:
      - period<=cnt, high_time<=hcnt.
      - done<=1, busy<=0, state<=IDLE.
- done: registered and high for exactly one cycle. period and high_time update on the same edge that raises done, and hold until the next done.
- Timeout:
  - Applies in ARM or MEAS when cnt reaches 2^CNT_W-1 with no closing rise.
  - Action: period<=0, high_time<=0, timeout<=1, done<=1 (one cycle), busy<=0, state<=IDLE.
  - Counters never wrap.
- start while busy: ignored, with no restart. start held high in IDLE after done starts a new measurement on the next cycle (back-to-back allowed).
- Rise coincident with timeout threshold: the rise wins; a valid result is posted.
- Reset asserted mid-measurement: immediate return to reset values. No done is produced.
- Constant-high sig_in: no rise after the first, so it times out, the same as constant-low.

Optional Feature:
- Macro: FREQ_METER_DUTY_EN.
- Defined: hcnt logic is present and high_time reports high cycles as above.
- Undefined: hcnt logic is removed; high_time is tied to 0; period, done and timeout behave identically.

Test Plan:
- Divider N=4 on sig_in, 50% duty, pulse start -> one done pulse; period=4, high_time=2 (duty enabled); busy low after done.
- Divider N=10 -> period=10, high_time=5. Repeat with N=5 odd -> period=5, high_time=2 or 3 per divider duty, stable over 3 back-to-back measurements with start held high.
- CNT_W=8, sig_in held at 0, pulse start -> done and timeout after 255 cycles in ARM; period=0. Next start clears timeout.
- Assert start during MEAS (N=4) -> ignored; exactly one done with period=4.
- Assert rst mid-MEAS -> busy, done, period, high_time = 0 within the same cycle (async). No done pulse. A fresh start afterwards measures period=4.
- Build without FREQ_METER_DUTY_EN, N=8 -> period=8, high_time=0.
